// File: rtl/range_set_enumerator_pkg.sv
// Shared types for the range set enumerator: FSM states, captured range slots,
// and small helpers used by the top level.
package range_enum_pkg;

  // Widest value supported; captured bounds are zero-extended to this width.
  localparam int RANGE_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [RANGE_MAX_W-1:0] lo;
    logic [RANGE_MAX_W-1:0] hi;
  } range_t;

  function automatic logic range_nonempty(range_t r);
    return r.lo <= r.hi;
  endfunction

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/range_set_enumerator_cursor.sv
// Value cursor for one range: load(lo,hi) primes it, step() advances it,
// at_end_o flags the inclusive upper bound before any increment can wrap.
module range_cursor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic [WIDTH-1:0] cur_o,
  output logic             at_end_o
);

  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  always_comb begin
    cur_d = cur_q;
    hi_d  = hi_q;
    if (load_i) begin
      cur_d = lo_i;
      hi_d  = hi_i;
    end else if (step_i) begin
      cur_d = cur_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      hi_q  <= '0;
    end else begin
      cur_q <= cur_d;
      hi_q  <= hi_d;
    end
  end

  assign cur_o    = cur_q;
  assign at_end_o = (cur_q == hi_q);

endmodule

// File: rtl/range_set_enumerator.sv
// Streams every member of up to NUM_RANGES inclusive [lo,hi] ranges, in slot
// order, tagged with the slot index. Ranges are snapshotted when start is taken.
module range_set_enumerator
  import range_enum_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_RANGES = 4,
  parameter int IDX_W      = idx_width(NUM_RANGES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_RANGES-1:0]       range_en,
  input  logic [NUM_RANGES*WIDTH-1:0] range_lo,
  input  logic [NUM_RANGES*WIDTH-1:0] range_hi,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_value,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        busy,
  output logic                        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RANGES - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_RANGES-1:0] en_q;
  range_t                ranges_q   [NUM_RANGES];
  range_t                ranges_cap [NUM_RANGES];

  range_t           slot;
  logic             accept_start;
  logic             slot_used;
  logic             last_slot;
  logic             xfer;
  logic             cur_load;
  logic             cur_step;
  logic             at_end;
  logic [WIDTH-1:0] cur;

  always_comb begin
    for (int i = 0; i < NUM_RANGES; i++) begin
      ranges_cap[i] = '0;
      ranges_cap[i].lo[WIDTH-1:0] = range_lo[i*WIDTH +: WIDTH];
      ranges_cap[i].hi[WIDTH-1:0] = range_hi[i*WIDTH +: WIDTH];
    end
  end

  // Output port: a value transfers on a rising edge where out_valid && out_ready
  // && !abort; while out_ready is low, out_value/out_idx hold their current value.
  assign slot         = ranges_q[idx_q];
  assign slot_used    = en_q[idx_q] && range_nonempty(slot);
  assign last_slot    = (idx_q == LAST_IDX);
  assign accept_start = (state_q == IDLE) && start && !abort;
  assign xfer         = (state_q == EMIT) && out_ready && !abort;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cur_load = 1'b0;
    cur_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_start) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (slot_used) begin
          cur_load = 1'b1;
          state_d  = EMIT;
        end else if (last_slot) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      EMIT: begin
        // End test precedes the increment so hi = all-ones never wraps.
        if (xfer) begin
          if (!at_end) begin
            cur_step = 1'b1;
          end else if (last_slot) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      cur_load = 1'b0;
      cur_step = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      for (int i = 0; i < NUM_RANGES; i++) ranges_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept_start) begin
        en_q <= range_en;
        for (int i = 0; i < NUM_RANGES; i++) ranges_q[i] <= ranges_cap[i];
      end
    end
  end

  range_cursor #(
    .WIDTH(WIDTH)
  ) u_cursor (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (cur_load),
    .step_i   (cur_step),
    .lo_i     (slot.lo[WIDTH-1:0]),
    .hi_i     (slot.hi[WIDTH-1:0]),
    .cur_o    (cur),
    .at_end_o (at_end)
  );

  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == SCAN) || (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign out_value = cur;
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_range_set_enumerator.sv
// Directed bench for range_set_enumerator: a 32-bit and an 8-bit instance share
// one clock and reset; each scenario task checks its own results inline.
module tb_range_set_enumerator;

  localparam int W  = 32;
  localparam int W8 = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           start, abort, out_ready, out_valid, busy, done;
  logic [N-1:0]   range_en;
  logic [N*W-1:0] range_lo, range_hi;
  logic [W-1:0]   out_value;
  logic [1:0]     out_idx;

  logic            start8, abort8, out_ready8, out_valid8, busy8, done8;
  logic [N-1:0]    range_en8;
  logic [N*W8-1:0] range_lo8, range_hi8;
  logic [W8-1:0]   out_value8;
  logic [1:0]      out_idx8;

  range_set_enumerator #(.WIDTH(W), .NUM_RANGES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .range_en(range_en), .range_lo(range_lo), .range_hi(range_hi),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  range_set_enumerator #(.WIDTH(W8), .NUM_RANGES(N)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .range_en(range_en8), .range_lo(range_lo8), .range_hi(range_hi8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_value(out_value8),
    .out_idx(out_idx8), .busy(busy8), .done(done8)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_idx_q[$];
  logic [W-1:0] got_q[$];
  logic [1:0]   got_idx_q[$];

  int first_valid, n_cycles, n_done, hold_err;
  bit timed_out;

  // ---------------- driver tasks ----------------
  task automatic set_range(input int slot, input logic [W-1:0] lo, input logic [W-1:0] hi);
    range_lo[slot*W +: W] = lo;
    range_hi[slot*W +: W] = hi;
  endtask

  task automatic set_range8(input int slot, input logic [W8-1:0] lo, input logic [W8-1:0] hi);
    range_lo8[slot*W8 +: W8] = lo;
    range_hi8[slot*W8 +: W8] = hi;
  endtask

  task automatic push_range(input longint lo, input longint hi, input logic [1:0] idx);
    for (longint v = lo; v <= hi; v++) begin
      exp_q.push_back(W'(v));
      exp_idx_q.push_back(idx);
    end
  endtask

  task automatic start_run(input bit sel8);
    @(negedge clk);
    if (sel8) start8 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start8 = 1'b0;
  endtask

  // Samples on falling edges; a value counts as transferred when valid && ready.
  task automatic collect(input bit sel8, input bit toggle, input int max_cycles);
    bit r, prev_stall, vld, dn;
    logic [W-1:0] v, prev_v;
    logic [1:0] id;
    r = 1'b1; prev_stall = 1'b0; prev_v = '0;
    first_valid = 0; n_cycles = 0; n_done = 0; hold_err = 0; timed_out = 1'b1;
    got_q.delete();
    got_idx_q.delete();
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      n_cycles++;
      out_ready  = r;
      out_ready8 = r;
      vld = sel8 ? out_valid8 : out_valid;
      v   = sel8 ? {{(W-W8){1'b0}}, out_value8} : out_value;
      id  = sel8 ? out_idx8 : out_idx;
      dn  = sel8 ? done8 : done;
      if (prev_stall && (!vld || v !== prev_v)) hold_err++;
      if (vld && first_valid == 0) first_valid = n_cycles;
      if (vld && r) begin
        got_q.push_back(v);
        got_idx_q.push_back(id);
      end
      prev_stall = vld && !r;
      prev_v     = v;
      if (dn) begin
        n_done++;
        timed_out = 1'b0;
        break;
      end
      if (toggle) r = ~r;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; abort = 0; out_ready = 0; range_en = '0; range_lo = '0; range_hi = '0;
    start8 = 0; abort8 = 0; out_ready8 = 0; range_en8 = '0; range_lo8 = '0; range_hi8 = '0;
    #12;
    checks++;
    if ({out_valid, busy, done, out_value, out_idx} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b b=%b d=%b val=%0d idx=%0d required all zero",
               out_valid, busy, done, out_value, out_idx);
    end
    checks++;
    if ({out_valid8, busy8, done8, out_value8, out_idx8} !== '0) begin
      failures++;
      $display("FAIL reset_outputs8 got v=%b b=%b d=%b val=%0d required all zero",
               out_valid8, busy8, done8, out_value8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_enabled();
    set_range(0, 16, 23); set_range(1, 32, 47); set_range(2, 60, 61); set_range(3, 0, 0);
    range_en = 4'b1111;
    exp_q.delete(); exp_idx_q.delete();
    push_range(16, 23, 0); push_range(32, 47, 1); push_range(60, 61, 2); push_range(0, 0, 3);
    start_run(0);
    collect(0, 0, 200);
    checks++;
    if (timed_out || n_done != 1) begin
      failures++;
      $display("FAIL all_done got done_count=%0d timeout=%0d required 1/0", n_done, timed_out);
    end
    checks++;
    if (first_valid != 2) begin
      failures++;
      $display("FAIL all_latency got first_valid_cycle=%0d required 2", first_valid);
    end
    checks++;
    if (n_cycles != 32) begin
      failures++;
      $display("FAIL all_cycles got %0d required 32", n_cycles);
    end
    checks++;
    if (got_q.size() != 27) begin
      failures++;
      $display("FAIL all_count got %0d required 27", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_idx_q[i] !== exp_idx_q[i]) begin
        failures++;
        $display("FAIL all_elem[%0d] got %0d/idx%0d required %0d/idx%0d",
                 i, got_q[i], got_idx_q[i], exp_q[i], exp_idx_q[i]);
      end
    end
    // Currently in the DONE cycle: a start here must be dropped.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle_start got busy=%b done=%b valid=%b required 0/0/0",
               busy, done, out_valid);
    end
  endtask

  task automatic test_masked();
    range_en = 4'b1010;
    exp_q.delete(); exp_idx_q.delete();
    push_range(32, 47, 1); push_range(0, 0, 3);
    start_run(0);
    collect(0, 0, 200);
    checks++;
    if (timed_out || n_done != 1) begin
      failures++;
      $display("FAIL mask_done got done_count=%0d timeout=%0d required 1/0", n_done, timed_out);
    end
    checks++;
    if (first_valid != 3 || n_cycles != 22) begin
      failures++;
      $display("FAIL mask_timing got first=%0d cycles=%0d required 3/22", first_valid, n_cycles);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL mask_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_idx_q[i] !== exp_idx_q[i]) begin
        failures++;
        $display("FAIL mask_elem[%0d] got %0d/idx%0d required %0d/idx%0d",
                 i, got_q[i], got_idx_q[i], exp_q[i], exp_idx_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_range(0, 5, 8);
    range_en = 4'b0001;
    exp_q.delete(); exp_idx_q.delete();
    push_range(5, 8, 0);
    start_run(0);
    collect(0, 1, 200);
    checks++;
    if (timed_out || n_done != 1) begin
      failures++;
      $display("FAIL bp_done got done_count=%0d timeout=%0d required 1/0", n_done, timed_out);
    end
    checks++;
    if (hold_err != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d unstable stalls required 0", hold_err);
    end
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL bp_count got %0d required 4", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_idx_q[i] !== exp_idx_q[i]) begin
        failures++;
        $display("FAIL bp_elem[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap8();
    set_range8(0, 254, 255); set_range8(1, 10, 20); set_range8(2, 0, 255); set_range8(3, 255, 255);
    range_en8 = 4'b1101;
    exp_q.delete(); exp_idx_q.delete();
    push_range(254, 255, 0); push_range(0, 255, 2); push_range(255, 255, 3);
    start_run(1);
    collect(1, 0, 400);
    checks++;
    if (timed_out || n_done != 1) begin
      failures++;
      $display("FAIL wrap_done got done_count=%0d timeout=%0d required 1/0", n_done, timed_out);
    end
    checks++;
    if (got_q.size() != 259) begin
      failures++;
      $display("FAIL wrap_count got %0d required 259", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_idx_q[i] !== exp_idx_q[i]) begin
        failures++;
        $display("FAIL wrap_elem[%0d] got %0d/idx%0d required %0d/idx%0d",
                 i, got_q[i], got_idx_q[i], exp_q[i], exp_idx_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    int xfers;
    bit saw_done;
    logic [W-1:0] held;
    set_range(0, 0, 9);
    range_en  = 4'b0001;
    out_ready = 1'b1;
    xfers = 0;
    held  = '1;
    got_q.delete();
    start_run(0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (xfers == 2) begin
          abort = 1'b1;
          held  = out_value;
          break;
        end
        got_q.push_back(out_value);
        xfers++;
      end
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got valid=%b busy=%b done=%b required 0/0/0", out_valid, busy, done);
    end
    checks++;
    if (xfers != 2 || held !== 2 || got_q.size() != 2 || got_q[0] !== 0 || got_q[1] !== 1) begin
      failures++;
      $display("FAIL abort_xfers got count=%0d third=%0d required 2 transfers (0,1) then 2 offered",
               xfers, held);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_no_done got done pulse required none");
    end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_with_abort got busy=%b required 0", busy);
    end
    exp_q.delete(); exp_idx_q.delete();
    push_range(0, 9, 0);
    start_run(0);
    collect(0, 0, 100);
    checks++;
    if (timed_out || n_done != 1 || got_q.size() != 10) begin
      failures++;
      $display("FAIL abort_restart got done=%0d count=%0d required 1/10", n_done, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL restart_elem[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit saw_done;
    set_range(0, 100, 103);
    range_en  = 4'b0001;
    out_ready = 1'b0;
    start_run(0);
    repeat (3) @(negedge clk);
    // New bounds plus a start while busy: neither may disturb the run.
    set_range(0, 200, 210);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 100 || out_idx !== 0) begin
      failures++;
      $display("FAIL busy_start_hold got valid=%b val=%0d idx=%0d required 1/100/0",
               out_valid, out_value, out_idx);
    end
    exp_q.delete(); exp_idx_q.delete();
    push_range(100, 103, 0);
    collect(0, 0, 100);
    checks++;
    if (timed_out || n_done != 1 || got_q.size() != 4) begin
      failures++;
      $display("FAIL busy_start_run got done=%0d count=%0d required 1/4", n_done, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL busy_start_elem[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
      end
    end
    set_range(2, 50, 60);
    range_en  = 4'b0100;
    out_ready = 1'b1;
    start_run(0);
    repeat (5) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 2) begin
      failures++;
      $display("FAIL pre_reset_emit got valid=%b idx=%0d required 1/2", out_valid, out_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, out_value, out_idx} !== '0) begin
      failures++;
      $display("FAIL async_reset got v=%b b=%b d=%b val=%0d idx=%0d required all zero",
               out_valid, busy, done, out_value, out_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || busy || out_valid) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL post_reset_idle got activity after reset required idle with no done");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_enabled();
    test_masked();
    test_backpressure();
    test_wrap8();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
